// File: rtl/cybercobra_mc.sv
// rtl/cybercobra_mc.sv - multicycle CYBERCOBRA core (FETCH / EXEC / HALT)
//
// Purpose: fetches one instruction word per request from an external
// instruction memory. It then executes the word against a 32x32 register file
// (x0 reads as zero) and updates the PC. A jump-to-self halts the core until reset.
//
// Ports:
//   clk_i          single clock, rising edge
//   rst_i          synchronous active-high reset
//   imem_req_o     fetch request, high only in FETCH
//   imem_addr_o    byte address of fetch (current PC)
//   imem_valid_i   fetch data valid, completes the request in the same cycle
//   imem_rdata_i   instruction word
//   sw_i           switch operand, sign-extended to 32 bits
//   sw_valid_i     sw_i holds valid data
//   sw_ack_o       one-cycle pulse when a switch-write instruction consumes sw_i
//   out_o          RA1 read data of the last executed instruction
//   halted_o       core is in HALT
//   instret_o      completed-instruction counter (only with CYBERCOBRA_INSTRET_EN)
//
// Optional feature macro: CYBERCOBRA_INSTRET_EN

module cybercobra_mc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          SW_W     = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [31:0]     imem_addr_o,
    input  logic            imem_valid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic [SW_W-1:0] sw_i,
    input  logic            sw_valid_i,
    output logic            sw_ack_o,
    output logic [31:0]     out_o,
    output logic            halted_o
`ifdef CYBERCOBRA_INSTRET_EN
    ,
    output logic [31:0]     instret_o
`endif
);

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SLTS = 5'b00010;
    localparam logic [4:0] ALU_SLTU = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_SRA  = 5'b01101;
    localparam logic [4:0] ALU_EQ   = 5'b11000;
    localparam logic [4:0] ALU_NE   = 5'b11001;
    localparam logic [4:0] ALU_LTS  = 5'b11100;
    localparam logic [4:0] ALU_GES  = 5'b11101;
    localparam logic [4:0] ALU_LTU  = 5'b11110;
    localparam logic [4:0] ALU_GEU  = 5'b11111;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] out_q;
    logic [31:0] rf [32];

    // instruction fields
    logic        f_j, f_b;
    logic [1:0]  f_ws;
    logic [4:0]  f_alu_op, f_ra1, f_ra2, f_wa;
    logic [7:0]  f_offs;
    logic [22:0] f_const;

    assign f_j      = ir_q[31];
    assign f_b      = ir_q[30];
    assign f_ws     = ir_q[29:28];
    assign f_alu_op = ir_q[27:23];
    assign f_ra1    = ir_q[22:18];
    assign f_ra2    = ir_q[17:13];
    assign f_offs   = ir_q[12:5];
    assign f_wa     = ir_q[4:0];
    assign f_const  = ir_q[27:5];

    logic [31:0] rd1, rd2;
    logic [31:0] alu_res;
    logic        alu_flag;
    logic [31:0] sw_ext;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        sw_wait;
    logic        halt_hit;
    logic        exec_done;
    logic        taken;
    logic [31:0] br_offs;
    logic [31:0] pc_next;

    assign rd1 = (f_ra1 == 5'd0) ? 32'd0 : rf[f_ra1];
    assign rd2 = (f_ra2 == 5'd0) ? 32'd0 : rf[f_ra2];

    // Comparison ops only drive the flag; their result is zero.
    always_comb begin
        alu_res  = 32'd0;
        alu_flag = 1'b0;
        case (f_alu_op)
            ALU_ADD:  alu_res  = rd1 + rd2;
            ALU_SUB:  alu_res  = rd1 - rd2;
            ALU_SLL:  alu_res  = rd1 << rd2[4:0];
            ALU_SLTS: alu_res  = {31'd0, $signed(rd1) < $signed(rd2)};
            ALU_SLTU: alu_res  = {31'd0, rd1 < rd2};
            ALU_XOR:  alu_res  = rd1 ^ rd2;
            ALU_SRL:  alu_res  = rd1 >> rd2[4:0];
            ALU_SRA:  alu_res  = $unsigned($signed(rd1) >>> rd2[4:0]);
            ALU_OR:   alu_res  = rd1 | rd2;
            ALU_AND:  alu_res  = rd1 & rd2;
            ALU_EQ:   alu_flag = (rd1 == rd2);
            ALU_NE:   alu_flag = (rd1 != rd2);
            ALU_LTS:  alu_flag = ($signed(rd1) < $signed(rd2));
            ALU_GES:  alu_flag = ($signed(rd1) >= $signed(rd2));
            ALU_LTU:  alu_flag = (rd1 < rd2);
            ALU_GEU:  alu_flag = (rd1 >= rd2);
            default:  alu_res  = 32'd0;
        endcase
    end

    assign sw_ext = 32'($signed(sw_i));

    always_comb begin
        wr_data = 32'd0;
        case (f_ws)
            2'b00:   wr_data = {{9{f_const[22]}}, f_const};
            2'b01:   wr_data = alu_res;
            2'b10:   wr_data = sw_ext;
            default: wr_data = 32'd0;
        endcase
    end

    assign wr_en    = !f_j && !f_b;
    assign sw_wait  = wr_en && (f_ws == 2'b10) && !sw_valid_i;
    assign halt_hit = f_j && (f_offs == 8'd0);

    // J dominates B; a jump-to-self yields pc_next == pc_q, so HALT keeps the PC.
    assign taken   = f_j || (f_b && alu_flag);
    assign br_offs = {{22{f_offs[7]}}, f_offs, 2'b00};
    assign pc_next = pc_q + (taken ? br_offs : 32'd4);

    always_comb begin
        state_d    = state_q;
        imem_req_o = 1'b0;
        sw_ack_o   = 1'b0;
        halted_o   = 1'b0;
        exec_done  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_valid_i) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!sw_wait) begin
                    exec_done = 1'b1;
                    sw_ack_o  = wr_en && (f_ws == 2'b10);
                    state_d   = halt_hit ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                halted_o = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            out_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_FETCH && imem_valid_i) begin
                ir_q <= imem_rdata_i;
            end
            if (exec_done) begin
                pc_q  <= pc_next;
                out_q <= rd1;
            end
        end
    end

    // Register file is intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (exec_done && wr_en && (f_wa != 5'd0)) begin
            rf[f_wa] <= wr_data;
        end
    end

    assign imem_addr_o = pc_q;
    assign out_o       = out_q;

`ifdef CYBERCOBRA_INSTRET_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instret_q <= 32'd0;
        end else if (exec_done) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_cybercobra_mc.sv
// tb/tb_cybercobra_mc.sv - scoreboard testbench for cybercobra_mc

module tb_cybercobra_mc;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          SW_W     = 16;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b01000;
    localparam logic [4:0] OP_XOR = 5'b00100;
    localparam logic [4:0] OP_EQ  = 5'b11000;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            imem_req_o;
    logic [31:0]     imem_addr_o;
    logic            imem_valid_i = 1'b0;
    logic [31:0]     imem_rdata_i = 32'd0;
    logic [SW_W-1:0] sw_i = '0;
    logic            sw_valid_i = 1'b0;
    logic            sw_ack_o;
    logic [31:0]     out_o;
    logic            halted_o;
`ifdef CYBERCOBRA_INSTRET_EN
    logic [31:0]     instret_o;
`endif

    cybercobra_mc #(
        .RESET_PC (RESET_PC),
        .SW_W     (SW_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_valid_i (imem_valid_i),
        .imem_rdata_i (imem_rdata_i),
        .sw_i         (sw_i),
        .sw_valid_i   (sw_valid_i),
        .sw_ack_o     (sw_ack_o),
        .out_o        (out_o),
        .halted_o     (halted_o)
`ifdef CYBERCOBRA_INSTRET_EN
        ,
        .instret_o    (instret_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] out;
        logic [31:0] pc_next;
        logic [31:0] fetch_addr;
        int          fetch_cyc;
        int          exec_cyc;
        int          acks;
        logic        halted;
    } exp_t;

    exp_t sb_q[$];

    function automatic logic [31:0] enc(input logic j, input logic b, input logic [1:0] ws,
                                        input logic [4:0] op, input logic [4:0] ra1,
                                        input logic [4:0] ra2, input logic [7:0] offs,
                                        input logic [4:0] wa);
        return {j, b, ws, op, ra1, ra2, offs, wa};
    endfunction

    function automatic logic [31:0] enc_c(input logic [22:0] c, input logic [4:0] wa);
        return {2'b00, 2'b00, c, wa};
    endfunction

    // Monitor: an instruction retires when imem_req_o rises again or HALT is entered.
    int          m_fetch = 0;
    int          m_exec  = 0;
    int          m_acks  = 0;
    logic [31:0] m_faddr = 32'd0;
    logic        prev_req  = 1'b1;
    logic        prev_halt = 1'b0;
    exp_t        m_e;

    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                m_fetch   = 0;
                m_exec    = 0;
                m_acks    = 0;
                prev_req  = 1'b1;
                prev_halt = 1'b0;
                sb_q.delete();
            end else begin
                if ((imem_req_o && !prev_req) || (halted_o && !prev_halt)) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_retire", 32'd1, 32'd0);
                    end else begin
                        m_e = sb_q.pop_front();
                        check("out_o", out_o, m_e.out);
                        check("next_pc", imem_addr_o, m_e.pc_next);
                        check("fetch_addr", m_faddr, m_e.fetch_addr);
                        check("fetch_cycles", 32'(m_fetch), 32'(m_e.fetch_cyc));
                        check("exec_cycles", 32'(m_exec), 32'(m_e.exec_cyc));
                        check("sw_ack_pulses", 32'(m_acks), 32'(m_e.acks));
                        check("halted_o", 32'(halted_o), 32'(m_e.halted));
                    end
                    m_fetch = 0;
                    m_exec  = 0;
                    m_acks  = 0;
                end
                if (halted_o) begin
                    check("req_in_halt", 32'(imem_req_o), 32'd0);
                end
                if (imem_req_o && !halted_o) begin
                    if (m_fetch == 0) begin
                        m_faddr = imem_addr_o;
                    end else begin
                        check("fetch_addr_stable", imem_addr_o, m_faddr);
                    end
                    m_fetch++;
                    if (sw_ack_o) begin
                        check("ack_in_fetch", 32'(sw_ack_o), 32'd0);
                    end
                end else if (!imem_req_o && !halted_o) begin
                    m_exec++;
                    if (sw_ack_o) begin
                        m_acks++;
                    end
                end
                prev_req  = imem_req_o;
                prev_halt = halted_o;
            end
        end
    end

    task automatic do_reset();
        imem_valid_i = 1'b0;
        sw_valid_i   = 1'b0;
        rst_i        = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_addr"}, imem_addr_o, RESET_PC);
        check({tag, "_req"}, 32'(imem_req_o), 32'd1);
        check({tag, "_halted"}, 32'(halted_o), 32'd0);
        check({tag, "_out"}, out_o, 32'd0);
        check({tag, "_ack"}, 32'(sw_ack_o), 32'd0);
    endtask

    // Plays instruction memory for one instruction; garbage with valid=1 is
    // presented during EXEC and must be ignored.
    task automatic run_instr(input logic [31:0] instr, input int fdly, input int sdly,
                             input logic [15:0] sw, input logic [31:0] exp_out,
                             input logic [31:0] exp_pc, input logic [31:0] exp_faddr,
                             input int exp_exec, input int exp_acks, input logic exp_halt);
        int   k;
        logic done;
        exp_t e;
        sw_i       = sw;
        sw_valid_i = 1'b0;
        k = 0;
        while (!imem_req_o && k < 20) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        if (!imem_req_o) begin
            check("fetch_req_timeout", 32'd0, 32'd1);
        end
        e.out        = exp_out;
        e.pc_next    = exp_pc;
        e.fetch_addr = exp_faddr;
        e.fetch_cyc  = fdly + 1;
        e.exec_cyc   = exp_exec;
        e.acks       = exp_acks;
        e.halted     = exp_halt;
        sb_q.push_back(e);
        for (int i = 0; i < fdly; i++) begin
            @(posedge clk_i);
            #1;
        end
        imem_valid_i = 1'b1;
        imem_rdata_i = instr;
        @(posedge clk_i);
        #1;
        imem_rdata_i = 32'hFFFF_FFFF;
        sw_valid_i   = (sdly == 0);
        k    = 0;
        done = 1'b0;
        while (!done && k < 60) begin
            @(posedge clk_i);
            #1;
            k++;
            if (k >= sdly) begin
                sw_valid_i = 1'b1;
            end
            if (imem_req_o || halted_o) begin
                done = 1'b1;
            end
        end
        if (!done) begin
            check("exec_timeout", 32'd0, 32'd1);
        end
        imem_valid_i = 1'b0;
        sw_valid_i   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(posedge clk_i);
        #1;
        do_reset();
        check_reset_state("reset");

        //        instr                                       fd sd sw        out           next_pc       faddr         ex ak h
        run_instr(enc_c(23'd5, 5'd1),                          0, 0, 16'h0000, 32'h0,        32'h4,        32'h0,        1, 0, 0);
        run_instr(enc_c(23'd7, 5'd3),                          3, 0, 16'h0000, 32'h0,        32'h8,        32'h4,        1, 0, 0);
        run_instr(enc(0, 0, 2'b10, OP_ADD, 1, 0, 8'h00, 2),    0, 5, 16'h8000, 32'h5,        32'hC,        32'h8,        6, 1, 0);
        run_instr(enc(0, 0, 2'b01, OP_ADD, 3, 0, 8'h00, 7),    0, 0, 16'h0000, 32'h7,        32'h10,       32'hC,        1, 0, 0);
        run_instr(enc(0, 0, 2'b01, OP_SUB, 2, 7, 8'h00, 5),    0, 0, 16'h0000, 32'hFFFF8000, 32'h14,       32'h10,       1, 0, 0);
        run_instr(enc(0, 1, 2'b00, OP_EQ, 3, 7, 8'hFE, 9),     0, 0, 16'h0000, 32'h7,        32'hC,        32'h14,       1, 0, 0);
        run_instr(enc_c(23'd6, 5'd8),                          0, 0, 16'h0000, 32'h0,        32'h10,       32'hC,        1, 0, 0);
        run_instr(enc(0, 1, 2'b11, OP_EQ, 8, 3, 8'hFE, 9),     0, 0, 16'h0000, 32'h6,        32'h14,       32'h10,       1, 0, 0);
        run_instr(enc(1, 1, 2'b00, OP_EQ, 8, 3, 8'h02, 9),     0, 0, 16'h0000, 32'h6,        32'h1C,       32'h14,       1, 0, 0);
        run_instr(enc(1, 0, 2'b00, OP_ADD, 5, 0, 8'hF9, 9),    0, 0, 16'h0000, 32'hFFFF7FF9, 32'h0,        32'h1C,       1, 0, 0);
        run_instr(enc(1, 0, 2'b00, OP_ADD, 7, 0, 8'hFF, 9),    0, 0, 16'h0000, 32'h7,        32'hFFFFFFFC, 32'h0,        1, 0, 0);
        run_instr(enc_c(23'h400000, 5'd10),                    0, 0, 16'h0000, 32'h0,        32'h0,        32'hFFFFFFFC, 1, 0, 0);
        run_instr(enc(0, 0, 2'b01, OP_XOR, 10, 0, 8'h00, 0),   0, 0, 16'h0000, 32'hFFC00000, 32'h4,        32'h0,        1, 0, 0);
        run_instr(enc(0, 0, 2'b11, OP_ADD, 0, 0, 8'h00, 11),   0, 0, 16'h0000, 32'h0,        32'h8,        32'h4,        1, 0, 0);
        run_instr(enc(0, 0, 2'b10, OP_ADD, 11, 0, 8'h00, 12),  0, 0, 16'h1234, 32'h0,        32'hC,        32'h8,        1, 1, 0);
        run_instr(enc(1, 0, 2'b00, OP_ADD, 12, 0, 8'h00, 13),  0, 0, 16'h0000, 32'h1234,     32'hC,        32'hC,        1, 0, 1);

        repeat (4) @(posedge clk_i);
        #1;
        check("halt_held", 32'(halted_o), 32'd1);
`ifdef CYBERCOBRA_INSTRET_EN
        check("instret_at_halt", instret_o, 32'd16);
`endif
        do_reset();
        check_reset_state("reset_from_halt");

        // Stalled switch write abandoned by reset: x12 must keep 0x1234.
        sw_i         = 16'hFFFF;
        sw_valid_i   = 1'b0;
        imem_valid_i = 1'b1;
        imem_rdata_i = enc(0, 0, 2'b10, OP_ADD, 0, 0, 8'h00, 12);
        @(posedge clk_i);
        #1;
        imem_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("stall_req", 32'(imem_req_o), 32'd0);
        check("stall_ack", 32'(sw_ack_o), 32'd0);
        check("stall_pc", imem_addr_o, RESET_PC);
        do_reset();
        check_reset_state("reset_from_stall");

        run_instr(enc(0, 0, 2'b11, OP_ADD, 12, 0, 8'h00, 0),   1, 0, 16'h0000, 32'h1234,     32'h4,        32'h0,        1, 0, 0);
`ifdef CYBERCOBRA_INSTRET_EN
        check("instret_after_reset", instret_o, 32'd1);
`endif

        repeat (3) @(posedge clk_i);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cybercobra_mc.md
CYBERCOBRA_MC -- requirements
Module: cybercobra_mc

Interface
REQ-001: Parameter RESET_PC, default 32'h0000_0000; PC value loaded on reset.
REQ-002: Parameter SW_W, default 16, legal 1..32; width of switch input, sign-extended to 32.
REQ-003: clk_i  input  1  single clock, all state updates on rising edge.
REQ-004: rst_i  input  1  synchronous, active-high reset.
REQ-005: imem_req_o  output  1  instruction fetch request.
REQ-006: imem_addr_o  output  32  byte address of fetch (current PC).
REQ-007: imem_valid_i  input  1  fetch data valid; completes request same cycle.
REQ-008: imem_rdata_i  input  32  instruction word.
REQ-009: sw_i  input  SW_W  switch operand.
REQ-010: sw_valid_i  input  1  sw_i holds valid data.
REQ-011: sw_ack_o  output  1  one-cycle pulse: sw_i consumed.
REQ-012: out_o  output  32  registered RA1 read data of last executed instruction.
REQ-013: halted_o  output  1  core is in HALT.

Function
REQ-014: Instruction fields SHALL be: J=[31], B=[30], WS=[29:28], ALUop=[27:23], RA1=[22:18], RA2=[17:13], OFFS=[12:5], WA=[4:0], CONST=[27:5].
REQ-015: FSM states SHALL be FETCH, EXEC, HALT; reset state FETCH.
REQ-016: FETCH: imem_req_o=1, imem_addr_o=PC; on imem_valid_i=1 latch imem_rdata_i into IR and go to EXEC next cycle; otherwise stay, request held.
REQ-017: EXEC: register file read via RA1/RA2, team ALU computes result and flag from ALUop; exactly one architectural update per instruction.
REQ-018: Register write enable SHALL be (J==0 && B==0); write data by WS: 00 sext(CONST,23->32), 01 ALU result, 10 sext(sw_i,SW_W->32), 11 zero.
REQ-019: Register x0 SHALL read zero; writes to x0 discarded.
REQ-020: Next PC SHALL be PC + {sext(OFFS),2'b00} when J=1 or (B=1 and flag=1), else PC+4; arithmetic modulo 2^32 (wrap from 32'hFFFF_FFFC+4 to 0).
REQ-021: When WS=10 with write enabled and sw_valid_i=0, EXEC SHALL stall: no RF write, no PC update, out_o unchanged.
REQ-022: When WS=10 instruction completes, sw_ack_o SHALL pulse high for exactly that EXEC cycle; never otherwise.
REQ-023: On EXEC completion out_o SHALL load RA1 read data and FSM returns to FETCH; minimum 2 cycles per instruction.
REQ-024: J=1 with OFFS=0 (jump to self) SHALL enter HALT instead of FETCH; PC unchanged; halted_o=1; only reset exits HALT.
REQ-025: J=1 and B=1 simultaneously: J wins, branch ignored.
REQ-026: imem_valid_i outside FETCH SHALL be ignored.

Reset
REQ-027: On rst_i=1 at a clock edge: PC=RESET_PC, state=FETCH, IR=0, out_o=0, sw_ack_o=0, halted_o=0, imem_req_o=1 from the following cycle.
REQ-028: Reset SHALL override any state, including mid-fetch, EXEC stall and HALT; an in-flight fetch is abandoned.
REQ-029: Register file contents are not reset.

Configuration
REQ-030: Macro CYBERCOBRA_INSTRET_EN defined: extra output instret_o (32) counts completed EXEC instructions (HALT entry counts), reset 0, wraps at 2^32; stalled cycles not counted.
REQ-031: Macro undefined: no instret_o port, no counter logic; all other behaviour identical.

Verification
REQ-032: Reset, imem_valid_i=1 always, IR=const 5 to x1 -> after 2 cycles x1=5, PC=4, imem_addr_o=4.
REQ-033: imem_valid_i delayed 3 cycles -> imem_req_o and imem_addr_o held stable 4 cycles, single instruction executed.
REQ-034: WS=10 to x2, sw_i=16'h8000, sw_valid_i raised 5 cycles late -> 5 stall cycles, then x2=32'hFFFF_8000, one sw_ack_o pulse.
REQ-035: B=1 with ALU equality op on x1=x3=7, OFFS=8'hFE -> PC decreases by 8; with x3=6 -> PC+4.
REQ-036: J=1, OFFS=0 at PC=12 -> halted_o=1, imem_req_o=0 thereafter; rst_i pulse -> PC=RESET_PC, halted_o=0.
REQ-037: CYBERCOBRA_INSTRET_EN build, 10 instructions including one 3-cycle sw stall -> instret_o=10.
